// File: rtl/booth_mult_arbiter_if.sv
// Bundles the requester, response and multiplier-side buses of booth_mult_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface booth_mult_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_mplier;
    logic [NREQ*N-1:0] req_mcand;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [2*N-1:0]    rsp_product;
    logic              rsp_err;

    logic              mult_start;
    logic [N-1:0]      mult_mplier;
    logic [N-1:0]      mult_mcand;
    logic              mult_done;
    logic [2*N-1:0]    mult_product;

    modport slave (
        input  req_valid, req_mplier, req_mcand, rsp_ready, mult_done, mult_product,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
               mult_start, mult_mplier, mult_mcand
    );

    modport master (
        output req_valid, req_mplier, req_mcand, rsp_ready, mult_done, mult_product,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
               mult_start, mult_mplier, mult_mcand
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin sharing of one Booth multiplier among NREQ requesters, with a
// watchdog that turns a hung multiplier into an error response.
//
// state   | meaning
// IDLE    | waiting for a request; grants and latches operands
// ISSUE   | one-cycle mult_start pulse, watchdog cleared
// WAIT    | waiting for mult_done or watchdog expiry
// CAPTURE | registering mult_product (valid the cycle after done)
// RESP    | holding the response until rsp_ready
module booth_mult_arbiter #(
    parameter int N       = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 n_reset,
    booth_mult_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 timeout_flag
);
    localparam int ID_W = $clog2(NREQ);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    logic [2:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [N-1:0]    mplier_q;
    logic [N-1:0]    mcand_q;
    logic [WD_W-1:0] watchdog;
    logic [2*N-1:0]  product_q;
    logic            err_q;
    logic            tflag_q;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] cand;

    // First valid lane strictly after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NREQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(NREQ - 1);
            id_q      <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            watchdog  <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
            tflag_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        id_q     <= gnt_id;
                        mplier_q <= bus.req_mplier[int'(gnt_id)*N +: N];
                        mcand_q  <= bus.req_mcand[int'(gnt_id)*N +: N];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.mult_done) begin
                        state <= CAPTURE;
                    end else if (watchdog == WD_LAST) begin
                        err_q     <= 1'b1;
                        tflag_q   <= 1'b1;
                        product_q <= '0;
                        state     <= RESP;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                CAPTURE: begin
                    product_q <= bus.mult_product;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rr_ptr <= id_q;
                        err_q  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant is combinational so operands are taken in the same cycle req_ready is seen.
    assign bus.req_ready   = (state == IDLE && n_reset && gnt_found)
                             ? (NREQ'(1) << gnt_id) : '0;
    assign bus.mult_start  = (state == ISSUE);
    assign bus.mult_mplier = mplier_q;
    assign bus.mult_mcand  = mcand_q;
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_id      = id_q;
    assign bus.rsp_product = product_q;
    assign bus.rsp_err     = err_q;
    assign busy            = (state != IDLE);
    assign timeout_flag    = tflag_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed scoreboard bench for booth_mult_arbiter (N=8, NREQ=4, TIMEOUT=16)
// with a cycle-accurate behavioural Booth multiplier that can be made to hang.
module tb_booth_mult_arbiter;
    localparam int N = 8;
    localparam int NREQ = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic n_reset;
    logic busy;
    logic timeout_flag;
    logic mult_hang;

    booth_mult_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    booth_mult_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .bus          (bus),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    // Multiplier model: done N/2 cycles after the start cycle, product one cycle later.
    logic [3:0]         m_cnt;
    logic signed [15:0] m_res;
    always @(posedge clk) begin
        if (!n_reset) begin
            m_cnt            <= '0;
            m_res            <= '0;
            bus.mult_product <= '0;
        end else if (bus.mult_start && !mult_hang) begin
            m_cnt <= 4'd5;
            m_res <= 16'($signed(bus.mult_mplier)) * 16'($signed(bus.mult_mcand));
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 4'd1;
            if (m_cnt == 4'd1) bus.mult_product <= m_res;
        end
    end
    assign bus.mult_done = (m_cnt == 4'd1);

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] prod;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (n_reset && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got response id %0d, expected none", bus.rsp_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                check("rsp_product", 64'(bus.rsp_product), 64'(e.prod));
                check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [41:0] all_outs();
        return {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err,
                bus.mult_start, bus.mult_mplier, bus.mult_mcand, busy, timeout_flag};
    endfunction

    task automatic set_lane(int lane, logic [7:0] a, logic [7:0] b);
        bus.req_mplier[lane*8 +: 8] = a;
        bus.req_mcand[lane*8 +: 8]  = b;
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 80) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Single-lane operation with rsp_ready high: grant, latency, start pulse, rsp drop.
    task automatic do_op(string name, int lane, logic [7:0] a, logic [7:0] b,
                         logic [15:0] prod, logic err, int lat);
        int cyc = 0;
        int starts = 0;
        int grants = 0;
        logic [3:0] oh;
        oh = 4'b0001 << lane;
        tick();
        set_lane(lane, a, b);
        bus.req_valid = oh;
        exp_q.push_back('{2'(lane), prod, err});
        @(negedge clk);
        check({name, "_grant"}, 64'(bus.req_ready), 64'(oh));
        tick();
        bus.req_valid = '0;
        do begin
            @(negedge clk);
            cyc++;
            starts += int'(bus.mult_start);
            grants += int'(bus.req_ready != 0);
        end while (!bus.rsp_valid && cyc < 60);
        check({name, "_latency"}, 64'(cyc), 64'(lat));
        check({name, "_start_pulses"}, 64'(starts), 64'd1);
        check({name, "_no_regrant"}, 64'(grants), 64'd0);
        @(negedge clk);
        check({name, "_rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        logic [15:0] lane_prod[4] = '{16'h002A, 16'hFFEE, 16'hFFF1, 16'h0038};
        int n;
        int cnt;
        logic [3:0] oh;

        n_reset = 1'b0;
        mult_hang = 1'b0;
        bus.req_valid = '0;
        bus.req_mplier = '0;
        bus.req_mcand = '0;
        bus.rsp_ready = 1'b0;
        tick();
        @(negedge clk);
        check("reset_outputs", 64'(all_outs()), 64'd0);
        tick();
        n_reset = 1'b1;
        bus.rsp_ready = 1'b1;

        // Lane 2 alone: 3 * -5
        do_op("t1", 2, 8'd3, 8'hFB, 16'hFFF1, 1'b0, 8);

        // Response stall with another lane waiting
        tick();
        bus.rsp_ready = 1'b0;
        set_lane(1, 8'hFE, 8'h09);
        set_lane(3, 8'hF9, 8'hF8);
        bus.req_valid = 4'b0010;
        exp_q.push_back('{2'd1, 16'hFFEE, 1'b0});
        @(negedge clk);
        check("t3_grant", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 4'b1000;
        n = 0;
        cnt = 0;
        do begin
            @(negedge clk);
            n++;
            cnt += int'(bus.req_ready != 0);
        end while (!bus.rsp_valid && n < 60);
        check("t3_latency", 64'(n), 64'd8);
        check("t3_no_grant_busy", 64'(cnt), 64'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("t3_hold", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.req_ready}),
                  64'({1'b1, 2'd1, 16'hFFEE, 4'b0000}));
        end
        tick();
        bus.rsp_ready = 1'b1;
        exp_q.push_back('{2'd3, 16'h0038, 1'b0});
        @(negedge clk);
        check("t3_no_grant_in_resp", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("t3_next_grant", 64'(bus.req_ready), 64'h8);
        tick();
        bus.req_valid = '0;
        drain("t3_drain");

        // Hung multiplier, then recovery
        check("t4_flag_before", 64'(timeout_flag), 64'd0);
        mult_hang = 1'b1;
        do_op("t4_timeout", 0, 8'd5, 8'd5, 16'h0000, 1'b1, 18);
        check("t4_flag_set", 64'(timeout_flag), 64'd1);
        mult_hang = 1'b0;
        do_op("t4_recover", 3, 8'hF9, 8'hF8, 16'h0038, 1'b0, 8);
        check("t4_flag_sticky", 64'(timeout_flag), 64'd1);

        // Reset during WAIT
        tick();
        set_lane(2, 8'd3, 8'hFB);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("t5_grant", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        check("t5_in_wait", 64'({busy, bus.rsp_valid, bus.mult_start}), 64'b100);
        tick();
        n_reset = 1'b0;
        tick();
        @(negedge clk);
        check("t5_reset_outputs", 64'(all_outs()), 64'd0);
        tick();
        n_reset = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(bus.rsp_valid);
        end
        check("t5_no_rsp", 64'(cnt), 64'd0);
        do_op("t5_fresh", 1, 8'hFE, 8'h09, 16'hFFEE, 1'b0, 8);

        // Round-robin from reset with every lane requesting
        tick();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        set_lane(0, 8'h07, 8'h06);
        set_lane(1, 8'hFE, 8'h09);
        set_lane(2, 8'h03, 8'hFB);
        set_lane(3, 8'hF9, 8'hF8);
        foreach (order[g]) exp_q.push_back('{2'(order[g]), lane_prod[order[g]], 1'b0});
        bus.req_valid = 4'b1111;
        foreach (order[g]) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.req_ready == 0 && n < 60);
            oh = 4'b0001 << order[g];
            check("t2_grant_order", 64'(bus.req_ready), 64'(oh));
        end
        tick();
        bus.req_valid = '0;
        drain("t2_drain");

        // Corner operands
        do_op("t6_max", 0, 8'h7F, 8'h7F, 16'h3F01, 1'b0, 8);
        do_op("t6_min", 1, 8'h80, 8'h80, 16'h4000, 1'b0, 8);
        do_op("t6_zero", 2, 8'h00, 8'h5A, 16'h0000, 1'b0, 8);
        do_op("t6_zero_b", 3, 8'hA5, 8'h00, 16'h0000, 1'b0, 8);
        drain("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
